audio_arbiter: RTL and testbench

//  Shares the single note generator (speaker driver) between N_REQ sound sources.

---
 rtl/audio_arbiter_if.sv | 35 +++
 rtl/audio_arbiter.sv | 163 ++++++++++++++++
 tb/tb_audio_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/audio_arbiter_if.sv
// Bus between the sound sources and the audio arbiter: level requests and
// per-source frequencies in, one-hot grant and the selected frequency out.
interface audio_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned FREQ_W = 24
);
   localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        i_req;
   logic [N_REQ*FREQ_W-1:0] i_freq;
   logic [N_REQ-1:0]        o_grant;
   logic [ID_W-1:0]         o_id;
   logic [FREQ_W-1:0]       o_freq;
   logic                    o_active;

   // Source side: drives requests and frequencies, observes the grant
   modport master (
      output i_req,
      output i_freq,
      input  o_grant,
      input  o_id,
      input  o_freq,
      input  o_active
   );

   // Arbiter side
   modport slave (
      input  i_req,
      input  i_freq,
      output o_grant,
      output o_id,
      output o_freq,
      output o_active
   );
endinterface

// File: rtl/audio_arbiter.sv
// Audio arbiter: shares one note generator between N_REQ sound sources.
// Fixed priority (highest index wins) with a minimum hold, counted in beat
// ticks, before a higher-priority source may preempt the current owner.
// Optional build macro AUDIO_ARB_GAP_EN inserts a silent GAP state (until the
// next tick) on every switch between two different owners.
module audio_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned FREQ_W   = 24,
   parameter int unsigned MIN_HOLD = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_tick,
   input  logic            i_enable,
   audio_arbiter_if.slave  bus
);
   localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1
`ifdef AUDIO_ARB_GAP_EN
      ,
      StGap   = 2'd2
`endif
   } state_e;

   state_e              r_state;
   logic [ID_W-1:0]     r_owner;
   logic [HOLD_W-1:0]   r_hold;
   logic [N_REQ-1:0]    r_grant;
   logic [ID_W-1:0]     r_id;
   logic [FREQ_W-1:0]   r_freq;
   logic                r_active;

   state_e              w_state_nxt;
   logic [ID_W-1:0]     w_owner_nxt;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic [FREQ_W-1:0]   w_freq_nxt;
   logic                w_active_nxt;
   logic [ID_W-1:0]     w_win;
   logic                w_any;
   logic [FREQ_W-1:0]   w_freq_win;
   logic [FREQ_W-1:0]   w_freq_own;

   // Highest requesting index and the frequencies of the winner and owner
   always_comb begin
      w_win      = '0;
      w_any      = 1'b0;
      w_freq_win = '0;
      w_freq_own = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (bus.i_req[k]) begin
            w_win = ID_W'(k);
            w_any = 1'b1;
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         if (ID_W'(k) == w_win)   w_freq_win = bus.i_freq[k*FREQ_W +: FREQ_W];
         if (ID_W'(k) == r_owner) w_freq_own = bus.i_freq[k*FREQ_W +: FREQ_W];
      end
   end

   // Next-state: grant, release, switch and hold-countdown decisions
   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_hold_nxt   = r_hold;
      w_freq_nxt   = '0;
      w_active_nxt = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (i_enable && w_any) begin
               w_state_nxt  = StGrant;
               w_owner_nxt  = w_win;
               w_hold_nxt   = HOLD_INIT;
               w_freq_nxt   = w_freq_win;
               w_active_nxt = 1'b1;
            end
         end

         StGrant: begin
            if (!i_enable || (!bus.i_req[r_owner] && !w_any)) begin
               // Disable overrides the hold; a lone release goes quiet
               w_state_nxt = StIdle;
               w_owner_nxt = '0;
               w_hold_nxt  = '0;
            end else if (!bus.i_req[r_owner] || ((w_win > r_owner) && (r_hold == '0))) begin
`ifdef AUDIO_ARB_GAP_EN
               w_state_nxt = StGap;
               w_owner_nxt = '0;
               w_hold_nxt  = '0;
`else
               // Reload takes precedence over a same-cycle tick decrement
               w_owner_nxt  = w_win;
               w_hold_nxt   = HOLD_INIT;
               w_freq_nxt   = w_freq_win;
               w_active_nxt = 1'b1;
`endif
            end else begin
               // Keep owner; a zero frequency is a rest, not a release
               w_freq_nxt   = w_freq_own;
               w_active_nxt = 1'b1;
               if (i_tick && (r_hold != '0)) w_hold_nxt = r_hold - HOLD_W'(1);
            end
         end

`ifdef AUDIO_ARB_GAP_EN
         StGap: begin
            if (!i_enable) begin
               w_state_nxt = StIdle;
            end else if (i_tick) begin
               if (w_any) begin
                  w_state_nxt  = StGrant;
                  w_owner_nxt  = w_win;
                  w_hold_nxt   = HOLD_INIT;
                  w_freq_nxt   = w_freq_win;
                  w_active_nxt = 1'b1;
               end else begin
                  w_state_nxt = StIdle;
               end
            end
         end
`endif

         default: begin
            w_state_nxt = StIdle;
            w_owner_nxt = '0;
            w_hold_nxt  = '0;
         end
      endcase
   end

   // State and registered outputs; async reset clears everything
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_owner  <= '0;
         r_hold   <= '0;
         r_grant  <= '0;
         r_id     <= '0;
         r_freq   <= '0;
         r_active <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_hold   <= w_hold_nxt;
         r_grant  <= w_active_nxt ? (N_REQ'(1) << w_owner_nxt) : '0;
         r_id     <= w_active_nxt ? w_owner_nxt : '0;
         r_freq   <= w_freq_nxt;
         r_active <= w_active_nxt;
      end
   end

   assign bus.o_grant  = r_grant;
   assign bus.o_id     = r_id;
   assign bus.o_freq   = r_freq;
   assign bus.o_active = r_active;

endmodule

// File: tb/tb_audio_arbiter.sv
// Directed self-checking bench for audio_arbiter (N_REQ=4, FREQ_W=24, MIN_HOLD=2).
module tb_audio_arbiter;
   localparam int unsigned N_REQ  = 4;
   localparam int unsigned FREQ_W = 24;

   logic i_clk;
   logic i_rst_n;
   logic i_tick;
   logic i_enable;

   int n_tests;
   int n_fail;

   audio_arbiter_if #(.N_REQ(N_REQ), .FREQ_W(FREQ_W)) u_bus ();

   audio_arbiter #(
      .N_REQ    (N_REQ),
      .FREQ_W   (FREQ_W),
      .MIN_HOLD (2)
   ) u_dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_tick   (i_tick),
      .i_enable (i_enable),
      .bus      (u_bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; land 1 time unit after the rising edge
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic tick_step();
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
   endtask

   task automatic set_freq(input int k, input logic [FREQ_W-1:0] f);
      u_bus.i_freq[k*FREQ_W +: FREQ_W] = f;
   endtask

   task automatic check_out(input string tag, input logic [3:0] g, input int id,
                            input logic [23:0] f);
      check_eq({tag, ".grant"}, 32'(u_bus.o_grant), 32'(g));
      check_eq({tag, ".id"}, 32'(u_bus.o_id), 32'(id));
      check_eq({tag, ".freq"}, 32'(u_bus.o_freq), 32'(f));
      check_eq({tag, ".active"}, 32'(u_bus.o_active), 32'(g != 4'b0));
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      i_rst_n       = 1'b0;
      i_tick        = 1'b0;
      i_enable      = 1'b0;
      u_bus.i_req   = '0;
      u_bus.i_freq  = '0;

      step();
      step();
      check_out("reset", 4'b0000, 0, 24'd0);

      // T1: first grant, then asynchronous reset mid-grant
      i_rst_n  = 1'b1;
      i_enable = 1'b1;
      set_freq(0, 24'd261);
      u_bus.i_req = 4'b0001;
      step();
      check_out("t1_grant", 4'b0001, 0, 24'd261);
      #3;
      i_rst_n = 1'b0;
      #1;
      check_out("t1_async", 4'b0000, 0, 24'd0);
      step();
      i_rst_n = 1'b1;
      step();
      check_out("t1_regrant", 4'b0001, 0, 24'd261);

      // T2: frequency pass-through, rest keeps the grant
      set_freq(0, 24'd233);
      step();
      check_out("t2_233", 4'b0001, 0, 24'd233);
      set_freq(0, 24'd0);
      step();
      check_out("t2_rest", 4'b0001, 0, 24'd0);

      // T3: hold of 2 ticks before index 3 preempts
      set_freq(0, 24'd261);
      set_freq(3, 24'd1000);
      u_bus.i_req = 4'b1001;
      step();
      check_out("t3_pend", 4'b0001, 0, 24'd261);
      tick_step();
      check_out("t3_tick1", 4'b0001, 0, 24'd261);
      step();
      check_out("t3_mid", 4'b0001, 0, 24'd261);
      tick_step();
      check_out("t3_tick2", 4'b0001, 0, 24'd261);
      step();
      check_out("t3_preempt", 4'b1000, 3, 24'd1000);

      // T4: lower index never preempts; owner release hands over gaplessly
      set_freq(1, 24'd500);
      u_bus.i_req = 4'b1010;
      for (int i = 0; i < 10; i++) begin
         tick_step();
         check_eq("t4_hold.grant", 32'(u_bus.o_grant), 32'(4'b1000));
         step();
      end
      u_bus.i_req = 4'b0010;
      step();
      check_out("t4_handover", 4'b0010, 1, 24'd500);

      // T5: enable drop mutes; requests ignored while disabled
      set_freq(2, 24'd392);
      u_bus.i_req = 4'b0100;
      step();
      check_out("t5_grant2", 4'b0100, 2, 24'd392);
      i_enable = 1'b0;
      step();
      check_out("t5_mute", 4'b0000, 0, 24'd0);
      u_bus.i_req = 4'b1111;
      step();
      check_out("t5_ignored", 4'b0000, 0, 24'd0);
      u_bus.i_req = 4'b0100;
      i_enable    = 1'b1;
      step();
      check_out("t5_reenable", 4'b0100, 2, 24'd392);

      // Lone release returns to idle
      u_bus.i_req = 4'b0000;
      step();
      check_out("release", 4'b0000, 0, 24'd0);

      // T6: owner 0 releases while index 2 requests
      u_bus.i_req = 4'b0001;
      step();
      check_out("t6_own0", 4'b0001, 0, 24'd261);
      u_bus.i_req = 4'b0100;
      step();
`ifdef AUDIO_ARB_GAP_EN
      check_out("t6_gap", 4'b0000, 0, 24'd0);
      step();
      check_out("t6_gap_hold", 4'b0000, 0, 24'd0);
      tick_step();
      check_out("t6_after_tick", 4'b0100, 2, 24'd392);
`else
      check_out("t6_switch", 4'b0100, 2, 24'd392);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
